ext_wb_arbiter: RTL and testbench

EXT_WB_ARBITER -- requirements
Module: ext_wb_arbiter

---
 rtl/ext_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ext_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ext_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ext_wb_arbiter
//  Description : Shares one registered extra writeback port among NrReq
//                result requesters. Each requester has its own small FIFO;
//                FIFO heads are granted round-robin, one per cycle, straight
//                into the writeback output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_wb_arbiter #(
  parameter int unsigned NrReq         = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned FifoDepth     = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_i,
  input  logic [NrReq-1:0]                        req_valid_i,
  output logic [NrReq-1:0]                        req_ready_o,
  input  logic [NrReq-1:0][TRANS_ID_BITS-1:0]     req_trans_id_i,
  input  logic [NrReq-1:0][XLEN-1:0]              req_result_i,
  input  logic [NrReq-1:0]                        req_ex_valid_i,
  output logic                                    wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]                wb_trans_id_o,
  output logic [XLEN-1:0]                         wb_result_o,
  output logic                                    wb_ex_valid_o,
  output logic [((NrReq > 1) ? $clog2(NrReq) : 1)-1:0] wb_src_o,
  output logic                                    busy_o
);

  localparam int unsigned c_SRC_W   = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam int unsigned c_PTR_W   = $clog2(FifoDepth);
  localparam int unsigned c_CNT_W   = $clog2(FifoDepth + 1);
  localparam int unsigned c_ENTRY_W = TRANS_ID_BITS + XLEN + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FifoDepth);

  // Per-requester FIFO state
  logic [c_CNT_W-1:0]   r_count  [NrReq];
  logic [c_PTR_W-1:0]   r_rd_ptr [NrReq];
  logic [c_PTR_W-1:0]   r_wr_ptr [NrReq];
  logic [c_ENTRY_W-1:0] r_mem    [NrReq][FifoDepth];

  // Round-robin pointer: index searched first on the next grant
  logic [c_SRC_W-1:0]   r_rr;

  // Writeback output register
  logic                     r_wb_valid;
  logic [TRANS_ID_BITS-1:0] r_wb_trans_id;
  logic [XLEN-1:0]          r_wb_result;
  logic                     r_wb_ex_valid;
  logic [c_SRC_W-1:0]       r_wb_src;

  logic [NrReq-1:0]     w_ready;
  logic [NrReq-1:0]     w_push;
  logic [NrReq-1:0]     w_pop;
  logic [NrReq-1:0]     w_nonempty;
  logic [c_ENTRY_W-1:0] w_head [NrReq];
  logic                 w_grant_valid;
  logic [c_SRC_W-1:0]   w_grant_idx;
  logic [c_ENTRY_W-1:0] w_sel;

  // Reduce a value in 0..2*NrReq-1 modulo NrReq (NrReq need not be a power of two)
  function automatic logic [c_SRC_W-1:0] f_wrap(input int unsigned a);
    if (a >= NrReq) return c_SRC_W'(a - NrReq);
    else            return c_SRC_W'(a);
  endfunction

  for (genvar i = 0; i < NrReq; i++) begin : g_req
    assign w_nonempty[i] = (r_count[i] != '0);
    // Ready looks only at the registered count, so a full FIFO refuses a
    // push even on an edge where it is also being popped.
    assign w_ready[i]    = (r_count[i] != c_FULL) && !flush_i;
    assign w_push[i]     = req_valid_i[i] && w_ready[i];
    assign w_pop[i]      = w_grant_valid && !flush_i && (w_grant_idx == c_SRC_W'(i));
    assign w_head[i]     = r_mem[i][r_rd_ptr[i]];
  end

  // Round-robin search for the first non-empty FIFO starting at r_rr
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < NrReq; k++) begin
      if (!w_grant_valid && w_nonempty[f_wrap(32'(r_rr) + 32'(k))]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = f_wrap(32'(r_rr) + 32'(k));
      end
    end
  end

  assign w_sel = w_head[w_grant_idx];

  // FIFO counts, pointers and arbitration pointer; flush empties everything
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrReq; i++) begin
        r_count[i]  <= '0;
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
      end
      r_rr <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NrReq; i++) begin
        r_count[i]  <= '0;
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
      end
      r_rr <= '0;
    end else begin
      for (int i = 0; i < NrReq; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + 1'b1;
          2'b01:   r_count[i] <= r_count[i] - 1'b1;
          default: r_count[i] <= r_count[i];
        endcase
      end
      if (w_grant_valid) r_rr <= f_wrap(32'(w_grant_idx) + 32'd1);
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NrReq; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wr_ptr[i]] <= {req_trans_id_i[i], req_result_i[i], req_ex_valid_i[i]};
      end
    end
  end

  // Writeback register: loads the popped head; fields hold when idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wb_valid    <= 1'b0;
      r_wb_trans_id <= '0;
      r_wb_result   <= '0;
      r_wb_ex_valid <= 1'b0;
      r_wb_src      <= '0;
    end else if (flush_i) begin
      r_wb_valid <= 1'b0;
    end else if (w_grant_valid) begin
      r_wb_valid    <= 1'b1;
      r_wb_trans_id <= w_sel[c_ENTRY_W-1 -: TRANS_ID_BITS];
      r_wb_result   <= w_sel[XLEN:1];
      r_wb_ex_valid <= w_sel[0];
      r_wb_src      <= w_grant_idx;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  assign req_ready_o   = w_ready;
  assign wb_valid_o    = r_wb_valid;
  assign wb_trans_id_o = r_wb_trans_id;
  assign wb_result_o   = r_wb_result;
  assign wb_ex_valid_o = r_wb_ex_valid;
  assign wb_src_o      = r_wb_src;
  assign busy_o        = (|w_nonempty) || r_wb_valid;

endmodule
`default_nettype wire

// File: tb/tb_ext_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_wb_arbiter
//  Description : Directed self-checking bench for ext_wb_arbiter
//                (NrReq=2, FifoDepth=2, TRANS_ID_BITS=3, XLEN=64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_wb_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [1:0]        vld;
  logic [1:0]        rdy;
  logic [1:0][2:0]   tid;
  logic [1:0][63:0]  res;
  logic [1:0]        ex;
  logic              wb_valid;
  logic [2:0]        wb_tid;
  logic [63:0]       wb_res;
  logic              wb_ex;
  logic [0:0]        wb_src;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  ext_wb_arbiter #(
    .NrReq(2), .TRANS_ID_BITS(3), .XLEN(64), .FifoDepth(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(vld), .req_ready_o(rdy),
    .req_trans_id_i(tid), .req_result_i(res), .req_ex_valid_i(ex),
    .wb_valid_o(wb_valid), .wb_trans_id_o(wb_tid), .wb_result_o(wb_res),
    .wb_ex_valid_o(wb_ex), .wb_src_o(wb_src), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; vld = '0; tid = '0; res = '0; ex = '0;

    // Reset values, before any clock edge
    #3;
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_busy",  64'(busy),     64'd0);
    chk("rst_ready", 64'(rdy),      64'd3);
    chk("rst_tid",   64'(wb_tid),   64'd0);
    chk("rst_res",   wb_res,        64'd0);
    chk("rst_src",   64'(wb_src),   64'd0);
    chk("rst_ex",    64'(wb_ex),    64'd0);
    tick(); tick();
    rst = 1'b0;

    // Single request: push on first edge after reset release
    vld[0] = 1'b1; tid[0] = 3'd3; res[0] = 64'hAA; ex[0] = 1'b0;
    tick();
    vld = '0;
    chk("t1_lat_valid", 64'(wb_valid), 64'd0);
    chk("t1_busy",      64'(busy),     64'd1);
    chk("t1_ready",     64'(rdy),      64'd3);
    tick();
    chk("t1_valid", 64'(wb_valid), 64'd1);
    chk("t1_tid",   64'(wb_tid),   64'd3);
    chk("t1_res",   wb_res,        64'hAA);
    chk("t1_src",   64'(wb_src),   64'd0);
    chk("t1_ex",    64'(wb_ex),    64'd0);
    tick();
    chk("t1_valid_off", 64'(wb_valid), 64'd0);
    chk("t1_busy_off",  64'(busy),     64'd0);
    chk("t1_tid_hold",  64'(wb_tid),   64'd3);

    // Flush while idle: rr back to 0, ready low during flush
    flush = 1'b1;
    #1;
    chk("fl0_ready", 64'(rdy), 64'd0);
    tick();
    flush = 1'b0;

    // Contention: both push together, rr=0
    vld = 2'b11; tid[0] = 3'd1; tid[1] = 3'd2;
    res[0] = 64'h100; res[1] = 64'h200; ex[0] = 1'b0; ex[1] = 1'b1;
    tick();
    vld = '0;
    tick();
    chk("t2a_valid", 64'(wb_valid), 64'd1);
    chk("t2a_tid",   64'(wb_tid),   64'd1);
    chk("t2a_src",   64'(wb_src),   64'd0);
    chk("t2a_res",   wb_res,        64'h100);
    chk("t2a_ex",    64'(wb_ex),    64'd0);
    tick();
    chk("t2b_valid", 64'(wb_valid), 64'd1);
    chk("t2b_tid",   64'(wb_tid),   64'd2);
    chk("t2b_src",   64'(wb_src),   64'd1);
    chk("t2b_res",   wb_res,        64'h200);
    chk("t2b_ex",    64'(wb_ex),    64'd1);
    tick();
    chk("t2_valid_off", 64'(wb_valid), 64'd0);
    chk("t2_busy_off",  64'(busy),     64'd0);

    // Full FIFO on req1 while req0 keeps pushing (rr=0 here)
    ex = '0;
    vld = 2'b11; tid[0] = 3'd4; tid[1] = 3'd5; res[0] = 64'h4; res[1] = 64'h5;
    tick();
    chk("t3_ready_e1", 64'(rdy), 64'd3);
    tid[0] = 3'd6; tid[1] = 3'd7; res[0] = 64'h6; res[1] = 64'h7;
    tick();
    chk("t3_tid_e2",   64'(wb_tid), 64'd4);
    chk("t3_src_e2",   64'(wb_src), 64'd0);
    chk("t3_ready_e2", 64'(rdy),    64'd1);
    vld = 2'b01; tid[0] = 3'd0; res[0] = 64'h8;
    tick();
    vld = '0;
    chk("t3_tid_e3",   64'(wb_tid), 64'd5);
    chk("t3_src_e3",   64'(wb_src), 64'd1);
    chk("t3_ready_e3", 64'(rdy),    64'd2);
    tick();
    chk("t3_tid_e4", 64'(wb_tid), 64'd6);
    chk("t3_src_e4", 64'(wb_src), 64'd0);
    chk("t3_res_e4", wb_res,      64'h6);
    tick();
    chk("t3_tid_e5", 64'(wb_tid), 64'd7);
    chk("t3_src_e5", 64'(wb_src), 64'd1);
    chk("t3_res_e5", wb_res,      64'h7);
    tick();
    chk("t3_tid_e6",   64'(wb_tid),   64'd0);
    chk("t3_src_e6",   64'(wb_src),   64'd0);
    chk("t3_valid_e6", 64'(wb_valid), 64'd1);
    tick();
    chk("t3_valid_e7", 64'(wb_valid), 64'd0);
    chk("t3_busy_e7",  64'(busy),     64'd0);

    // Fairness: flush to bring rr to 0, then both continuously valid
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vld = 2'b11; tid[0] = 3'd2; tid[1] = 3'd6; res[0] = 64'h22; res[1] = 64'h66;
    tick();
    chk("t4_first_valid", 64'(wb_valid), 64'd0);
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("t4_valid", 64'(wb_valid), 64'd1);
      chk("t4_src",   64'(wb_src),   64'(n % 2));
      chk("t4_tid",   64'(wb_tid),   (n % 2 == 0) ? 64'd2 : 64'd6);
    end
    vld = '0;

    // Flush with entries buffered
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("t5a_valid", 64'(wb_valid), 64'd0);
    chk("t5a_busy",  64'(busy),     64'd0);
    chk("t5a_ready", 64'(rdy),      64'd3);
    vld = 2'b11; tid[0] = 3'd1; tid[1] = 3'd3;
    tick();
    chk("t5_busy_buf", 64'(busy), 64'd1);
    vld = 2'b01; tid[0] = 3'd7;
    flush = 1'b1;
    #1;
    chk("t5_ready_flush", 64'(rdy), 64'd0);
    tick();
    flush = 1'b0; vld = '0;
    #1;
    chk("t5b_valid", 64'(wb_valid), 64'd0);
    chk("t5b_busy",  64'(busy),     64'd0);
    chk("t5b_ready", 64'(rdy),      64'd3);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("t5_no_stale", 64'(wb_valid), 64'd0);
    end

    // Reset mid-stream with three entries buffered
    vld = 2'b11; tid[0] = 3'd1; tid[1] = 3'd3;
    tick();
    tid[0] = 3'd2; tid[1] = 3'd4;
    tick();
    vld = '0;
    chk("t6_pre_valid", 64'(wb_valid), 64'd1);
    chk("t6_pre_tid",   64'(wb_tid),   64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(wb_valid), 64'd0);
    chk("t6_rst_busy",  64'(busy),     64'd0);
    chk("t6_rst_ready", 64'(rdy),      64'd3);
    chk("t6_rst_tid",   64'(wb_tid),   64'd0);
    chk("t6_rst_src",   64'(wb_src),   64'd0);
    tick();
    rst = 1'b0;
    vld = 2'b10; tid[1] = 3'd5; res[1] = 64'h55;
    tick();
    vld = '0;
    tick();
    chk("t6_new_valid", 64'(wb_valid), 64'd1);
    chk("t6_new_tid",   64'(wb_tid),   64'd5);
    chk("t6_new_src",   64'(wb_src),   64'd1);
    chk("t6_new_res",   wb_res,        64'h55);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("t6_no_stale", 64'(wb_valid), 64'd0);
    end
    chk("t6_busy_end", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
